// File: rtl/spart_pkg.sv
// Shared constants and types for the serial receive path.
package spart_pkg;

   // parity_mode encodings; 2'b11 is handled exactly like PAR_NONE
   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;

   localparam int OVERSAMPLE = 16;
   localparam int SAMPLE_W   = $clog2(OVERSAMPLE);

   // the three mid-bit samples voted on for every bit
   localparam logic [SAMPLE_W-1:0] SAMPLE_EARLY = SAMPLE_W'(7);
   localparam logic [SAMPLE_W-1:0] SAMPLE_MID   = SAMPLE_W'(8);
   localparam logic [SAMPLE_W-1:0] SAMPLE_LATE  = SAMPLE_W'(9);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } rx_state_e;

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   function automatic logic parity_enabled(input logic [1:0] mode);
      return (mode == PAR_EVEN) || (mode == PAR_ODD);
   endfunction

endpackage

// File: rtl/spart_sync_fifo.sv
// Receive FIFO, first-word fall-through; head reads as zero while empty.
module spart_sync_fifo import spart_pkg::*; #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             push_ok, pop_ok;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign count   = count_q;
   assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

   // pop only when data is present; push when space exists or a pop frees a slot
   always_comb begin
      pop_ok   = pop & ~empty;
      push_ok  = push & (~full | pop_ok);
      wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
   end

   // pointer and occupancy registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // storage array, written only on an accepted push
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/spart_rx_core.sv
// Oversampling serial receiver: synchroniser, tick generator, frame FSM,
// sticky error flags and receive FIFO.
//
// state  | meaning
// IDLE   | line idle, waiting for a falling edge
// START  | qualifying the start bit (glitch reject)
// DATA   | shifting in data bits, LSB first
// PARITY | checking the parity bit
// STOP   | checking the stop bit, pushing good frames
module spart_rx_core import spart_pkg::*; #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            rxd,
   input  logic [15:0]                     baud_div,
   input  logic [1:0]                      parity_mode,
   input  logic                            rd_en,
   input  logic                            err_clr,
   output logic [DATA_BITS-1:0]            rd_data,
   output logic                            rx_empty,
   output logic                            rx_full,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] rx_count,
   output logic                            frame_err,
   output logic                            parity_err,
   output logic                            overrun_err
);

   localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

   logic                 sync1_q, sync2_q, prev_q;
   rx_state_e            state_q, state_d;
   logic [15:0]          tick_cnt_q, tick_cnt_d;
   logic [15:0]          baud_q, baud_d;
   logic [1:0]           pmode_q, pmode_d;
   logic [SAMPLE_W-1:0]  samp_cnt_q, samp_cnt_d;
   logic [3:0]           bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic                 s7_q, s7_d, s8_q, s8_d;
   logic                 par_bad_q, par_bad_d;
   logic                 push_q, push_d;
   logic [DATA_BITS-1:0] push_data_q, push_data_d;
   logic                 frame_err_q, frame_err_d;
   logic                 parity_err_q, parity_err_d;
   logic                 overrun_err_q, overrun_err_d;
   logic                 tick, decide, bit_val, start_edge;
   logic                 frame_evt, parity_evt, overrun_evt;

   assign frame_err   = frame_err_q;
   assign parity_err  = parity_err_q;
   assign overrun_err = overrun_err_q;

   // next-state logic for the frame FSM, its timers and the error flags
   always_comb begin
      tick        = (state_q != ST_IDLE) && (tick_cnt_q == baud_q);
      decide      = tick && (samp_cnt_q == SAMPLE_LATE);
      bit_val     = majority3(s7_q, s8_q, sync2_q);
      start_edge  = prev_q & ~sync2_q;
      state_d     = state_q;
      tick_cnt_d  = tick_cnt_q;
      baud_d      = baud_q;
      pmode_d     = pmode_q;
      samp_cnt_d  = samp_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      shreg_d     = shreg_q;
      s7_d        = s7_q;
      s8_d        = s8_q;
      par_bad_d   = par_bad_q;
      push_d      = 1'b0;
      push_data_d = push_data_q;
      frame_evt   = 1'b0;
      parity_evt  = 1'b0;

      if (state_q != ST_IDLE) begin
         tick_cnt_d = tick ? 16'd0 : tick_cnt_q + 16'd1;
         if (tick) begin
            samp_cnt_d = samp_cnt_q + SAMPLE_W'(1);
            if (samp_cnt_q == SAMPLE_EARLY) s7_d = sync2_q;
            if (samp_cnt_q == SAMPLE_MID)   s8_d = sync2_q;
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (start_edge) begin
               state_d    = ST_START;
               tick_cnt_d = 16'd0;
               samp_cnt_d = '0;
               bit_cnt_d  = 4'd0;
               par_bad_d  = 1'b0;
               baud_d     = baud_div;
               pmode_d    = parity_mode;
            end
         end
         ST_START: begin
            if (decide) state_d = bit_val ? ST_IDLE : ST_DATA;
         end
         ST_DATA: begin
            if (decide) begin
               shreg_d   = {bit_val, shreg_q[DATA_BITS-1:1]};
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q == LAST_BIT)
                  state_d = parity_enabled(pmode_q) ? ST_PARITY : ST_STOP;
            end
         end
         ST_PARITY: begin
            if (decide) begin
               par_bad_d = (^shreg_q) ^ bit_val ^ (pmode_q == PAR_ODD);
               state_d   = ST_STOP;
            end
         end
         ST_STOP: begin
            if (decide) begin
               state_d     = ST_IDLE;
               frame_evt   = ~bit_val;
               parity_evt  = par_bad_q;
               push_d      = bit_val & ~par_bad_q;
               push_data_d = shreg_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      overrun_evt   = push_q & rx_full & ~rd_en;
      frame_err_d   = frame_evt   | (frame_err_q   & ~err_clr);
      parity_err_d  = parity_evt  | (parity_err_q  & ~err_clr);
      overrun_err_d = overrun_evt | (overrun_err_q & ~err_clr);
   end

   // synchroniser, FSM state and registered outputs
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1_q       <= 1'b1;
         sync2_q       <= 1'b1;
         prev_q        <= 1'b1;
         state_q       <= ST_IDLE;
         tick_cnt_q    <= 16'd0;
         baud_q        <= 16'd0;
         pmode_q       <= PAR_NONE;
         samp_cnt_q    <= '0;
         bit_cnt_q     <= 4'd0;
         shreg_q       <= '0;
         s7_q          <= 1'b1;
         s8_q          <= 1'b1;
         par_bad_q     <= 1'b0;
         push_q        <= 1'b0;
         push_data_q   <= '0;
         frame_err_q   <= 1'b0;
         parity_err_q  <= 1'b0;
         overrun_err_q <= 1'b0;
      end else begin
         sync1_q       <= rxd;
         sync2_q       <= sync1_q;
         prev_q        <= sync2_q;
         state_q       <= state_d;
         tick_cnt_q    <= tick_cnt_d;
         baud_q        <= baud_d;
         pmode_q       <= pmode_d;
         samp_cnt_q    <= samp_cnt_d;
         bit_cnt_q     <= bit_cnt_d;
         shreg_q       <= shreg_d;
         s7_q          <= s7_d;
         s8_q          <= s8_d;
         par_bad_q     <= par_bad_d;
         push_q        <= push_d;
         push_data_q   <= push_data_d;
         frame_err_q   <= frame_err_d;
         parity_err_q  <= parity_err_d;
         overrun_err_q <= overrun_err_d;
      end
   end

   spart_sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push_q),
      .wr_data (push_data_q),
      .pop     (rd_en),
      .rd_data (rd_data),
      .full    (rx_full),
      .empty   (rx_empty),
      .count   (rx_count)
   );

endmodule

// File: tb/tb_spart_rx_core.sv
// Bench for spart_rx_core: frame-level reference model (queue + flags)
// compared every cycle while the line is quiet, plus literal spot checks.
module tb_spart_rx_core;

   localparam int DB    = 8;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          rxd;
   logic [15:0]   baud_div;
   logic [1:0]    parity_mode;
   logic          rd_en;
   logic          err_clr;
   logic [DB-1:0] rd_data;
   logic          rx_empty;
   logic          rx_full;
   logic [2:0]    rx_count;
   logic          frame_err;
   logic          parity_err;
   logic          overrun_err;

   spart_rx_core #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .rxd         (rxd),
      .baud_div    (baud_div),
      .parity_mode (parity_mode),
      .rd_en       (rd_en),
      .err_clr     (err_clr),
      .rd_data     (rd_data),
      .rx_empty    (rx_empty),
      .rx_full     (rx_full),
      .rx_count    (rx_count),
      .frame_err   (frame_err),
      .parity_err  (parity_err),
      .overrun_err (overrun_err)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_pass   = 0;
   bit         chk_en   = 1'b0;
   logic [7:0] exp_q[$];
   bit         m_frame, m_par, m_ovr;
   int         sz;
   logic [7:0] head;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // model comparison on the falling edge whenever no frame is in flight
   always @(negedge clk) begin
      if (chk_en) begin
         sz   = exp_q.size();
         head = (sz > 0) ? exp_q[0] : 8'h00;
         check("rx_empty",    32'(rx_empty),    32'(sz == 0));
         check("rx_full",     32'(rx_full),     32'(sz == DEPTH));
         check("rx_count",    32'(rx_count),    32'(sz));
         check("rd_data",     32'(rd_data),     32'(head));
         check("frame_err",   32'(frame_err),   32'(m_frame));
         check("parity_err",  32'(parity_err),  32'(m_par));
         check("overrun_err", 32'(overrun_err), 32'(m_ovr));
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got still running expected finished");
      $fatal(1);
   end

   task automatic drive_bit(input logic v, input int n);
      rxd = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // full frame on the line; model updated once the stop bit has been sent
   task automatic send_frame(input logic [7:0] d, input int bd, input logic [1:0] pm,
                             input bit bad_par, input bit bad_stop);
      int   n;
      bit   pen;
      logic pbit;
      n   = 16 * (bd + 1);
      pen = (pm == 2'b01) || (pm == 2'b10);
      chk_en      = 1'b0;
      baud_div    = 16'(bd);
      parity_mode = pm;
      rxd         = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      baud_div    = 16'($urandom);
      parity_mode = 2'($urandom);
      repeat (n - 10) @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) drive_bit(d[i], n);
      if (pen) begin
         pbit = (pm == 2'b01) ? ^d : ~(^d);
         if (bad_par) pbit = ~pbit;
         drive_bit(pbit, n);
      end
      drive_bit(bad_stop ? 1'b0 : 1'b1, n);
      rxd = 1'b1;
      if (bad_stop) m_frame = 1'b1;
      if (pen && bad_par) m_par = 1'b1;
      if (!bad_stop && !(pen && bad_par)) begin
         if (exp_q.size() < DEPTH) exp_q.push_back(d);
         else m_ovr = 1'b1;
      end
   endtask

   task automatic settle();
      repeat (2) @(posedge clk);
      #1;
      chk_en = 1'b1;
   endtask

   task automatic read_one();
      @(negedge clk);
      rd_en = 1'b1;
      @(posedge clk);
      #1;
      rd_en = 1'b0;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
   endtask

   task automatic clear_errs();
      @(negedge clk);
      err_clr = 1'b1;
      @(posedge clk);
      #1;
      err_clr = 1'b0;
      m_frame = 1'b0;
      m_par   = 1'b0;
      m_ovr   = 1'b0;
   endtask

   initial begin
      logic [7:0] d;
      int         bd;
      logic [1:0] pm;
      bit         bp, bs;

      rst = 1'b0; rxd = 1'b1; baud_div = 16'd162; parity_mode = 2'b00;
      rd_en = 1'b0; err_clr = 1'b0;
      m_frame = 1'b0; m_par = 1'b0; m_ovr = 1'b0;
      @(posedge clk);
      #1;
      chk_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset_empty", 32'(rx_empty), 32'd1);
      check("reset_count", 32'(rx_count), 32'd0);
      check("reset_rd_data", 32'(rd_data), 32'd0);
      rst = 1'b1;
      repeat (4) @(posedge clk);
      #1;

      // 8N1 at the nominal divider
      send_frame(8'h55, 162, 2'b00, 1'b0, 1'b0);
      settle();
      check("b55_data", 32'(rd_data), 32'h55);
      check("b55_count", 32'(rx_count), 32'd1);
      check("b55_empty", 32'(rx_empty), 32'd0);
      read_one();

      // short low pulse must be rejected, then a normal frame follows
      baud_div = 16'd162; parity_mode = 2'b00;
      drive_bit(1'b0, 489);
      drive_bit(1'b1, 2500);
      check("glitch_frame_err", 32'(frame_err), 32'd0);
      check("glitch_empty", 32'(rx_empty), 32'd1);
      send_frame(8'h3C, 3, 2'b00, 1'b0, 1'b0);
      settle();
      check("b3c_data", 32'(rd_data), 32'h3C);
      read_one();

      // even parity with the wrong parity bit
      send_frame(8'h2A, 3, 2'b01, 1'b1, 1'b0);
      settle();
      check("par_err_set", 32'(parity_err), 32'd1);
      check("par_err_empty", 32'(rx_empty), 32'd1);
      clear_errs();

      // stop bit low
      send_frame(8'hAA, 3, 2'b00, 1'b0, 1'b1);
      settle();
      check("frame_err_set", 32'(frame_err), 32'd1);
      clear_errs();
      check("frame_err_clr", 32'(frame_err), 32'd0);

      // fill, overrun, drain
      for (int i = 1; i <= 4; i++) send_frame(8'(i), 3, 2'b00, 1'b0, 1'b0);
      settle();
      check("fifo_full4", 32'(rx_full), 32'd1);
      check("fifo_no_ovr", 32'(overrun_err), 32'd0);
      send_frame(8'h05, 3, 2'b00, 1'b0, 1'b0);
      settle();
      check("fifo_ovr", 32'(overrun_err), 32'd1);
      check("fifo_count", 32'(rx_count), 32'd4);
      for (int i = 1; i <= 4; i++) begin
         check("fifo_read", 32'(rd_data), 32'(i));
         read_one();
      end
      check("fifo_drained", 32'(rx_empty), 32'd1);
      read_one();
      check("fifo_empty_read", 32'(rx_count), 32'd0);
      clear_errs();

      // randomized frames, modes, faults, reads and clears
      for (int i = 0; i < 30; i++) begin
         d  = 8'($urandom);
         bd = $urandom_range(1, 3);
         pm = 2'($urandom);
         bp = ($urandom_range(0, 5) == 0);
         bs = ($urandom_range(0, 5) == 0);
         send_frame(d, bd, pm, bp, bs);
         if (bs || $urandom_range(0, 1) == 0) begin
            settle();
            repeat ($urandom_range(0, 3)) read_one();
            if ($urandom_range(0, 3) == 0) clear_errs();
            repeat ($urandom_range(0, 20)) @(posedge clk);
            #1;
         end
      end
      settle();

      // reset during the third data bit aborts the frame
      send_frame(8'h11, 2, 2'b01, 1'b1, 1'b0);
      settle();
      chk_en = 1'b0;
      baud_div = 16'd3; parity_mode = 2'b00;
      drive_bit(1'b0, 64);
      drive_bit(1'b0, 64);
      drive_bit(1'b1, 64);
      drive_bit(1'b0, 32);
      rst = 1'b0;
      rxd = 1'b1;
      @(posedge clk);
      #1;
      exp_q.delete();
      m_frame = 1'b0; m_par = 1'b0; m_ovr = 1'b0;
      chk_en = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("rst_mid_parity", 32'(parity_err), 32'd0);
      rst = 1'b1;
      repeat (128) @(posedge clk);
      #1;
      send_frame(8'hC3, 3, 2'b00, 1'b0, 1'b0);
      settle();
      check("bc3_data", 32'(rd_data), 32'hC3);
      check("bc3_count", 32'(rx_count), 32'd1);
      repeat (4) @(posedge clk);
      #1;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
